// File: rtl/apb3_slave_mux.sv
// apb3_slave_mux: fans one upstream APB3 slave port out to NUM_SLV downstream APB3 slaves.
// Latency: setup at T -> m setup T+1, m access T+2; zero-wait slave answers at T+3, decode error at T+1.
// Backpressure: s_PREADY stays low until the selected slave answers or the TIMEOUT watchdog fires.
// Ports: io_systemClk/io_systemReset clock and async reset; s_* upstream APB3 slave side;
//        m_* downstream APB3 master side (one-hot m_PSEL, packed m_PRDATA slices per slave);
//        timeout_irq one-cycle pulse per watchdog expiry, timeout_cnt saturating expiry count.
module apb3_slave_mux #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_SLV    = 4,
  parameter int                    SEL_BITS   = 2,
  parameter int                    TIMEOUT    = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                          io_systemClk,
  input  logic                          io_systemReset,
  input  logic [ADDR_WIDTH-1:0]         s_PADDR,
  input  logic                          s_PSEL,
  input  logic                          s_PENABLE,
  input  logic                          s_PWRITE,
  input  logic [DATA_WIDTH-1:0]         s_PWDATA,
  output logic                          s_PREADY,
  output logic [DATA_WIDTH-1:0]         s_PRDATA,
  output logic                          s_PSLVERROR,
  output logic [ADDR_WIDTH-1:0]         m_PADDR,
  output logic [NUM_SLV-1:0]            m_PSEL,
  output logic                          m_PENABLE,
  output logic                          m_PWRITE,
  output logic [DATA_WIDTH-1:0]         m_PWDATA,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] m_PRDATA,
  input  logic [NUM_SLV-1:0]            m_PREADY,
  input  logic [NUM_SLV-1:0]            m_PSLVERROR,
  output logic                          timeout_irq,
  output logic [7:0]                    timeout_cnt
);

  localparam int SLOTS  = 2 ** SEL_BITS;
  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  abort_q, abort_d;
  logic                  irq_q, irq_d;
  logic [7:0]            tcnt_q, tcnt_d;

  // Every index value gets a slot; slots past NUM_SLV read as unmapped and never ready,
  // so the decoder can index by the raw address bits without range checks.
  logic [DATA_WIDTH-1:0] slot_rdata [SLOTS];
  logic [SLOTS-1:0]      slot_rdy, slot_err, slot_map;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < NUM_SLV) begin : g_map
      assign slot_rdata[g] = m_PRDATA[g*DATA_WIDTH +: DATA_WIDTH];
      assign slot_rdy[g]   = m_PREADY[g];
      assign slot_err[g]   = m_PSLVERROR[g];
      assign slot_map[g]   = 1'b1;
    end else begin : g_unmap
      assign slot_rdata[g] = '0;
      assign slot_rdy[g]   = 1'b0;
      assign slot_err[g]   = 1'b0;
      assign slot_map[g]   = 1'b0;
    end
  end

  logic [SEL_BITS-1:0] s_idx;
  assign s_idx = s_PADDR[ADDR_WIDTH-1 -: SEL_BITS];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wait_d  = wait_q;
    abort_d = abort_q;
    irq_d   = 1'b0;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_PSEL && !s_PENABLE) begin
          addr_d  = {{SEL_BITS{1'b0}}, s_PADDR[ADDR_WIDTH-SEL_BITS-1:0]};
          wdata_d = s_PWDATA;
          write_d = s_PWRITE;
          idx_d   = s_idx;
          abort_d = 1'b0;
          wait_d  = '0;
          if (slot_map[s_idx]) begin
            state_d = S_SETUP;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: begin
        // A master that lets go of PSEL mid-transfer no longer expects an answer.
        if (!s_PSEL) abort_d = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!s_PSEL) abort_d = 1'b1;
        wait_d = wait_q + 1'b1;
        // Ready is checked first so a slave answering on the last allowed cycle is not timed out.
        if (slot_rdy[idx_q]) begin
          rdata_d = slot_rdata[idx_q];
          err_d   = slot_err[idx_q];
          state_d = S_RESP;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          irq_d   = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      irq_q   <= irq_d;
      tcnt_q  <= tcnt_d;
    end
  end

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_sel
    assign m_PSEL[g] = ((state_q == S_SETUP) || (state_q == S_ACCESS)) && (idx_q == SEL_BITS'(g));
  end

  assign m_PENABLE   = (state_q == S_ACCESS);
  assign m_PADDR     = addr_q;
  assign m_PWRITE    = write_q;
  assign m_PWDATA    = wdata_q;
  // An aborted transfer still passes through RESP but presents nothing upstream.
  assign s_PREADY    = (state_q == S_RESP) && !abort_q;
  assign s_PRDATA    = s_PREADY ? rdata_q : '0;
  assign s_PSLVERROR = s_PREADY && err_q;
  assign timeout_irq = irq_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_apb3_slave_mux.sv
// tb_apb3_slave_mux: directed transfers against a timeline model of the mux.
// Main instance uses default parameters; a second 3-slave, TIMEOUT=2 instance covers
// decode errors and counter saturation.
module tb_apb3_slave_mux;
  localparam int TMO = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic [11:0]  s_PADDR;
  logic         s_PSEL, s_PENABLE, s_PWRITE;
  logic [31:0]  s_PWDATA;
  logic         s_PREADY, s_PSLVERROR;
  logic [31:0]  s_PRDATA;
  logic [11:0]  m_PADDR;
  logic [3:0]   m_PSEL;
  logic         m_PENABLE, m_PWRITE;
  logic [31:0]  m_PWDATA;
  logic [127:0] m_PRDATA;
  logic [3:0]   m_PREADY, m_PSLVERROR;
  logic         timeout_irq;
  logic [7:0]   timeout_cnt;

  apb3_slave_mux u_dut (
    .io_systemClk(clk), .io_systemReset(rst),
    .s_PADDR(s_PADDR), .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PWDATA(s_PWDATA), .s_PREADY(s_PREADY), .s_PRDATA(s_PRDATA), .s_PSLVERROR(s_PSLVERROR),
    .m_PADDR(m_PADDR), .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
    .m_PWDATA(m_PWDATA), .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERROR(m_PSLVERROR),
    .timeout_irq(timeout_irq), .timeout_cnt(timeout_cnt)
  );

  // small instance: 3 slaves, short watchdog
  logic [11:0]  e_s_PADDR;
  logic         e_s_PSEL, e_s_PENABLE, e_s_PWRITE;
  logic [31:0]  e_s_PWDATA;
  logic         e_s_PREADY, e_s_PSLVERROR;
  logic [31:0]  e_s_PRDATA;
  logic [11:0]  e_m_PADDR;
  logic [2:0]   e_m_PSEL;
  logic         e_m_PENABLE, e_m_PWRITE;
  logic [31:0]  e_m_PWDATA;
  logic [95:0]  e_m_PRDATA;
  logic [2:0]   e_m_PREADY, e_m_PSLVERROR;
  logic         e_timeout_irq;
  logic [7:0]   e_timeout_cnt;

  apb3_slave_mux #(.NUM_SLV(3), .TIMEOUT(2)) u_err (
    .io_systemClk(clk), .io_systemReset(rst),
    .s_PADDR(e_s_PADDR), .s_PSEL(e_s_PSEL), .s_PENABLE(e_s_PENABLE), .s_PWRITE(e_s_PWRITE),
    .s_PWDATA(e_s_PWDATA), .s_PREADY(e_s_PREADY), .s_PRDATA(e_s_PRDATA), .s_PSLVERROR(e_s_PSLVERROR),
    .m_PADDR(e_m_PADDR), .m_PSEL(e_m_PSEL), .m_PENABLE(e_m_PENABLE), .m_PWRITE(e_m_PWRITE),
    .m_PWDATA(e_m_PWDATA), .m_PRDATA(e_m_PRDATA), .m_PREADY(e_m_PREADY), .m_PSLVERROR(e_m_PSLVERROR),
    .timeout_irq(e_timeout_irq), .timeout_cnt(e_timeout_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_PREADY"},    64'(s_PREADY),    64'd0);
    chk({tag, "_s_PRDATA"},    64'(s_PRDATA),    64'd0);
    chk({tag, "_s_PSLVERROR"}, 64'(s_PSLVERROR), 64'd0);
    chk({tag, "_m_PADDR"},     64'(m_PADDR),     64'd0);
    chk({tag, "_m_PSEL"},      64'(m_PSEL),      64'd0);
    chk({tag, "_m_PENABLE"},   64'(m_PENABLE),   64'd0);
    chk({tag, "_m_PWRITE"},    64'(m_PWRITE),    64'd0);
    chk({tag, "_m_PWDATA"},    64'(m_PWDATA),    64'd0);
    chk({tag, "_irq"},         64'(timeout_irq), 64'd0);
    chk({tag, "_tcnt"},        64'(timeout_cnt), 64'd0);
  endtask

  // Transaction timeline: setup at tx_T, downstream select for tx_n+1 cycles, answer at tx_R.
  logic        tx_active = 1'b0;
  int          tx_T, tx_n, tx_R, tx_idx;
  logic [11:0] tx_addr;
  logic [31:0] tx_wdata, tx_rdata;
  logic        tx_write, tx_err, tx_timeout, tx_aborted;
  int          model_cnt = 0;

  always @(negedge clk) begin
    logic [3:0]  e_sel;
    logic        e_en, e_rdy, e_er, e_irq;
    logic [31:0] e_rd;
    e_sel = '0; e_en = 1'b0; e_rdy = 1'b0; e_er = 1'b0; e_irq = 1'b0; e_rd = '0;
    if (rst) begin
      model_cnt = 0;
      chk_all_zero("rst");
    end else begin
      if (tx_active) begin
        if (cyc >= tx_T + 1 && cyc <= tx_T + 1 + tx_n) begin
          e_sel = 4'b0001 << tx_idx;
          e_en  = (cyc >= tx_T + 2);
          chk("m_PADDR",  64'(m_PADDR),  64'(tx_addr));
          chk("m_PWDATA", 64'(m_PWDATA), 64'(tx_wdata));
          chk("m_PWRITE", 64'(m_PWRITE), 64'(tx_write));
        end
        if (cyc == tx_R) begin
          if (tx_timeout && model_cnt < 255) model_cnt++;
          e_irq = tx_timeout;
          e_rdy = !tx_aborted;
          e_rd  = tx_aborted ? 32'd0 : tx_rdata;
          e_er  = !tx_aborted && tx_err;
        end
      end
      chk("m_PSEL",      64'(m_PSEL),      64'(e_sel));
      chk("m_PENABLE",   64'(m_PENABLE),   64'(e_en));
      chk("s_PREADY",    64'(s_PREADY),    64'(e_rdy));
      chk("s_PRDATA",    64'(s_PRDATA),    64'(e_rd));
      chk("s_PSLVERROR", 64'(s_PSLVERROR), 64'(e_er));
      chk("timeout_irq", 64'(timeout_irq), 64'(e_irq));
      chk("timeout_cnt", 64'(timeout_cnt), 64'(model_cnt));
    end
  end

  // Unselected slaves chatter with random data/ready/error; the selected one stays silent.
  task automatic junk(input int idx);
    for (int i = 0; i < 4; i++) begin
      m_PRDATA[i*32 +: 32] = $urandom;
      m_PREADY[i]          = 1'($urandom_range(0, 1));
      m_PSLVERROR[i]       = 1'($urandom_range(0, 1));
    end
    m_PREADY[idx] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_PSEL = 1'b0; s_PENABLE = 1'b0;
      m_PREADY = '0; m_PSLVERROR = '0; m_PRDATA = '0;
    end
  endtask

  logic [3:0]  snap_psel;
  logic [11:0] snap_paddr;
  logic [31:0] snap_pwdata;
  logic        snap_rdy2;

  // w: index of the access cycle on which the slave is ready (>= TMO means never).
  // abort_k / rst_k: cycle offset from setup where PSEL drops / reset hits (0 = never).
  task automatic xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                      input int w, input logic [31:0] rd, input logic er,
                      input int abort_k, input int rst_k);
    int n, idx;
    @(posedge clk); #1;
    idx = int'(addr[11:10]);
    if (w < TMO) begin
      n = w + 1; tx_timeout = 1'b0; tx_rdata = rd; tx_err = er;
    end else begin
      n = TMO; tx_timeout = 1'b1; tx_rdata = 32'hDEADBEEF; tx_err = 1'b1;
    end
    tx_T = cyc; tx_idx = idx; tx_n = n; tx_R = cyc + 2 + n;
    tx_addr = {2'b00, addr[9:0]}; tx_wdata = wd; tx_write = wr;
    tx_aborted = (abort_k > 0); tx_active = 1'b1;
    s_PADDR = addr; s_PWRITE = wr; s_PWDATA = wd; s_PSEL = 1'b1; s_PENABLE = 1'b0;
    junk(idx);
    for (int k = 1; k <= n + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin snap_psel = m_PSEL; snap_paddr = m_PADDR; snap_pwdata = m_PWDATA; end
      if (k == 2) snap_rdy2 = s_PREADY;
      s_PENABLE = 1'b1;
      if (abort_k > 0 && k >= abort_k) begin s_PSEL = 1'b0; s_PENABLE = 1'b0; end
      junk(idx);
      if (k == w + 2) begin
        m_PREADY[idx] = 1'b1; m_PRDATA[idx*32 +: 32] = rd; m_PSLVERROR[idx] = er;
      end
      if (k == rst_k) begin
        #1 rst = 1'b1; tx_active = 1'b0; s_PSEL = 1'b0; s_PENABLE = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk); #1 rst = 1'b0;
        break;
      end
    end
  endtask

  task automatic e_xfer(input logic [11:0] addr, output int lat, output logic [31:0] rd,
                        output logic er, output logic sel_seen);
    lat = -1; rd = '0; er = 1'b0; sel_seen = 1'b0;
    @(posedge clk); #1;
    e_s_PADDR = addr; e_s_PSEL = 1'b1; e_s_PENABLE = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      e_s_PENABLE = 1'b1;
      sel_seen = sel_seen | (|e_m_PSEL);
      if (e_s_PREADY) begin lat = k; rd = e_s_PRDATA; er = e_s_PSLVERROR; break; end
    end
    @(posedge clk); #1;
    e_s_PSEL = 1'b0; e_s_PENABLE = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er, sel;
    s_PADDR = '0; s_PSEL = 0; s_PENABLE = 0; s_PWRITE = 0; s_PWDATA = '0;
    m_PRDATA = '0; m_PREADY = '0; m_PSLVERROR = '0;
    e_s_PADDR = '0; e_s_PSEL = 0; e_s_PENABLE = 0; e_s_PWRITE = 0; e_s_PWDATA = '0;
    e_m_PRDATA = {32'h33333333, 32'h22222222, 32'h11111111};
    e_m_PREADY = 3'b111; e_m_PSLVERROR = 3'b000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // zero-wait write to slave 1
    xfer(12'h404, 1'b1, 32'h12345678, 0, 32'h0, 1'b0, 0, 0);
    chk("t1_psel",   64'(snap_psel),   64'h2);
    chk("t1_paddr",  64'(snap_paddr),  64'h004);
    chk("t1_pwdata", 64'(snap_pwdata), 64'h12345678);
    chk("t1_rdy_T2", 64'(snap_rdy2),   64'd0);
    chk("t1_rdy_T3", 64'(s_PREADY),    64'd1);
    chk("t1_err",    64'(s_PSLVERROR), 64'd0);
    idle(1);

    // read from slave 3, ready on its 5th access cycle
    xfer(12'hC10, 1'b0, 32'h0, 4, 32'hA5A5A5A5, 1'b0, 0, 0);
    chk("t2_rdata", 64'(s_PRDATA), 64'hA5A5A5A5);
    idle(1);
    chk("t2_one_cycle_rdy",  64'(s_PREADY), 64'd0);
    chk("t2_one_cycle_data", 64'(s_PRDATA), 64'd0);

    // back-to-back with PSEL held high
    xfer(12'h808, 1'b1, 32'hCAFEF00D, 2, 32'h0, 1'b0, 0, 0);
    xfer(12'h010, 1'b0, 32'h0, 0, 32'h13579BDF, 1'b0, 0, 0);
    chk("b2b_rdata", 64'(s_PRDATA), 64'h13579BDF);
    idle(2);

    // slave error response
    xfer(12'h400, 1'b0, 32'h0, 1, 32'h0BADF00D, 1'b1, 0, 0);
    chk("slverr", 64'(s_PSLVERROR), 64'd1);
    idle(1);

    // upstream abort during access
    xfer(12'h800, 1'b1, 32'h11112222, 3, 32'h0, 1'b0, 2, 0);
    chk("abort_rdy", 64'(s_PREADY), 64'd0);
    idle(1);

    // slave 0 never ready
    xfer(12'h000, 1'b0, 32'h0, 100000, 32'h0, 1'b0, 0, 0);
    chk("tmo_irq",   64'(timeout_irq), 64'd1);
    chk("tmo_cnt",   64'(timeout_cnt), 64'd1);
    chk("tmo_rdata", 64'(s_PRDATA),    64'hDEADBEEF);
    chk("tmo_err",   64'(s_PSLVERROR), 64'd1);
    idle(1);
    chk("tmo_irq_pulse", 64'(timeout_irq), 64'd0);

    // ready on the last allowed cycle wins
    xfer(12'h000, 1'b0, 32'h0, 255, 32'h77778888, 1'b0, 0, 0);
    chk("edge_irq",   64'(timeout_irq), 64'd0);
    chk("edge_rdata", 64'(s_PRDATA),    64'h77778888);
    chk("edge_cnt",   64'(timeout_cnt), 64'd1);
    idle(1);

    // reset during access, then a clean transfer
    xfer(12'hC00, 1'b0, 32'h0, 20, 32'h0, 1'b0, 0, 5);
    chk("rst_cnt", 64'(timeout_cnt), 64'd0);
    idle(1);
    xfer(12'h808, 1'b0, 32'h0, 1, 32'h24681357, 1'b0, 0, 0);
    chk("post_rst_rdata", 64'(s_PRDATA), 64'h24681357);
    idle(1);

    // decode error on the 3-slave instance
    e_xfer(12'hC00, lat, rd, er, sel);
    chk("dec_lat",   64'(lat), 64'd1);
    chk("dec_err",   64'(er),  64'd1);
    chk("dec_rdata", 64'(rd),  64'hDEADBEEF);
    chk("dec_psel",  64'(sel), 64'd0);
    e_xfer(12'h800, lat, rd, er, sel);
    chk("e_ok_lat",   64'(lat), 64'd3);
    chk("e_ok_rdata", 64'(rd),  64'h33333333);
    chk("e_ok_psel",  64'(sel), 64'd1);
    e_m_PREADY = 3'b000;
    e_xfer(12'h400, lat, rd, er, sel);
    chk("e_tmo_lat", 64'(lat),           64'd4);
    chk("e_tmo_cnt", 64'(e_timeout_cnt), 64'd1);
    for (int i = 0; i < 259; i++) e_xfer(12'h400, lat, rd, er, sel);
    chk("e_tmo_sat", 64'(e_timeout_cnt), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
